// File: rtl/riscv_ex_pkg.sv
// Shared types and width helpers for the EX retire queue and its match units.
package riscv_ex_pkg;

    // Widest unit index ever stored (NUM_UNITS is at most 8).
    localparam int UNIT_MAX_W = 3;

    typedef struct packed {
        logic [UNIT_MAX_W-1:0] unit;
        logic                  rdy;
    } ex_entry_t;

    function automatic int unit_w(input int num_units);
        return (num_units <= 2) ? 1 : $clog2(num_units);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_ex_retire_match.sv
// Finds the oldest candidate slot, scanning forward from the read pointer.
module riscv_ex_retire_match #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] cand,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic             hit,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] slot;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (!hit && cand[slot]) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/riscv_ex_retire.sv
// In-order retire queue: out-of-order unit results are parked and released in issue order.
module riscv_ex_retire
    import riscv_ex_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NUM_UNITS = 4,
    parameter  int DEPTH     = 4,
    localparam int UNIT_W    = unit_w(NUM_UNITS),
    localparam int CNT_W     = cnt_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      iss_valid,
    input  logic [UNIT_W-1:0]         iss_unit,
    input  logic [XLEN-1:0]           iss_pc,
    output logic                      iss_ready,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*XLEN-1:0] unit_r,
    output logic [NUM_UNITS-1:0]      unit_ack,
    output logic                      out_valid,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_r,
    output logic [UNIT_W-1:0]         out_unit,
    input  logic                      out_ready,
    output logic                      ex_stall,
    output logic [CNT_W-1:0]          count,
    output logic                      err
);

    localparam int PTR_W = $clog2(DEPTH);

    ex_entry_t        ctrl_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  r_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    logic [DEPTH-1:0]     occ;
    logic [DEPTH-1:0]     cand [NUM_UNITS];
    logic [NUM_UNITS-1:0] hit;
    logic [PTR_W-1:0]     idx  [NUM_UNITS];
    logic [PTR_W-1:0]     off;
    logic                 push, pop, err_set;

    assign iss_ready = count < CNT_W'(DEPTH);
    assign ex_stall  = !iss_ready;
    assign push      = iss_valid && iss_ready && !flush;
    assign out_valid = (count != '0) && ctrl_q[rd_ptr].rdy;
    assign pop       = out_valid && out_ready && !flush;
    assign out_pc    = pc_q[rd_ptr];
    assign out_r     = (count == '0) ? '0 : r_q[rd_ptr];
    assign out_unit  = ctrl_q[rd_ptr].unit[UNIT_W-1:0];
    assign err_set   = |(unit_done & ~hit);

    // Only entries already in the queue before this edge may complete.
    always_comb begin
        off = '0;
        occ = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off    = PTR_W'(j) - rd_ptr;
            occ[j] = CNT_W'(off) < count;
        end
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand[k] = '0;
            for (int j = 0; j < DEPTH; j++)
                cand[k][j] = occ[j] && !ctrl_q[j].rdy &&
                             (ctrl_q[j].unit == UNIT_MAX_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_match
        riscv_ex_retire_match #(.DEPTH(DEPTH)) u_match (
            .cand   (cand[k]),
            .rd_ptr (rd_ptr),
            .hit    (hit[k]),
            .idx    (idx[k])
        );
    end

    always_comb begin
        unit_ack = '0;
        for (int k = 0; k < NUM_UNITS; k++)
            unit_ack[k] = unit_done[k] && hit[k] && !flush;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                ctrl_q[i] <= '0;
        end else begin
            if (err_set)
                err <= 1'b1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                for (int i = 0; i < DEPTH; i++)
                    ctrl_q[i].rdy <= 1'b0;
            end else begin
                if (push) begin
                    ctrl_q[wr_ptr] <= '{unit: UNIT_MAX_W'(iss_unit), rdy: 1'b0};
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                for (int k = 0; k < NUM_UNITS; k++)
                    if (unit_ack[k])
                        ctrl_q[idx[k]].rdy <= 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: payload storage has no reset; it is only observed behind a set rdy bit or nonzero count.
    always_ff @(posedge clk) begin
        if (push)
            pc_q[wr_ptr] <= iss_pc;
        for (int k = 0; k < NUM_UNITS; k++)
            if (unit_ack[k])
                r_q[idx[k]] <= unit_r[k*XLEN +: XLEN];
    end

endmodule

// File: tb/tb_riscv_ex_retire.sv
// Directed and random checks of riscv_ex_retire against an in-order queue model.
module tb_riscv_ex_retire;

    localparam int XLEN   = 32;
    localparam int NU     = 4;
    localparam int DEPTH  = 4;
    localparam int UNIT_W = 2;
    localparam int CNT_W  = 3;

    logic                 clk, rst, flush, iss_valid, iss_ready, out_valid, out_ready, ex_stall, err;
    logic [UNIT_W-1:0]    iss_unit, out_unit;
    logic [XLEN-1:0]      iss_pc, out_pc, out_r;
    logic [NU-1:0]        unit_done, unit_ack;
    logic [NU*XLEN-1:0]   unit_r;
    logic [CNT_W-1:0]     count;

    riscv_ex_retire #(.XLEN(XLEN), .NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_pc(iss_pc), .iss_ready(iss_ready),
        .unit_done(unit_done), .unit_r(unit_r), .unit_ack(unit_ack),
        .out_valid(out_valid), .out_pc(out_pc), .out_r(out_r), .out_unit(out_unit),
        .out_ready(out_ready), .ex_stall(ex_stall), .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              unit;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] r;
        bit              rdy;
    } m_entry_t;

    m_entry_t mq[$];
    bit       m_err;
    int       checks   = 0;
    int       failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_pending(input int k);
        foreach (mq[i])
            if (mq[i].unit == k && !mq[i].rdy)
                return i;
        return -1;
    endfunction

    task automatic compare_all();
        logic [NU-1:0] eack;
        int sz;
        sz   = mq.size();
        eack = '0;
        for (int k = 0; k < NU; k++)
            if (unit_done[k] && !flush && find_pending(k) >= 0)
                eack[k] = 1'b1;
        check("iss_ready", iss_ready, sz < DEPTH);
        check("ex_stall", ex_stall, sz >= DEPTH);
        check("count", count, sz);
        check("out_valid", out_valid, sz > 0 && mq[0].rdy);
        if (sz == 0)
            check("out_r_empty", out_r, 0);
        else if (mq[0].rdy) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_r", out_r, mq[0].r);
            check("out_unit", out_unit, mq[0].unit);
        end
        check("unit_ack", unit_ack, eack);
        check("err", err, m_err);
    endtask

    task automatic model_update();
        bit pop, push;
        int p;
        if (rst) begin
            mq.delete();
            m_err = 0;
            return;
        end
        pop  = !flush && mq.size() > 0 && mq[0].rdy && out_ready;
        push = !flush && iss_valid && mq.size() < DEPTH;
        for (int k = 0; k < NU; k++)
            if (unit_done[k]) begin
                p = find_pending(k);
                if (p < 0)
                    m_err = 1;
                else if (!flush) begin
                    mq[p].r   = unit_r[k*XLEN +: XLEN];
                    mq[p].rdy = 1;
                end
            end
        if (flush)
            mq.delete();
        else begin
            if (pop)
                void'(mq.pop_front());
            if (push)
                mq.push_back('{unit: int'(iss_unit), pc: iss_pc, r: '0, rdy: 1'b0});
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush = 0; iss_valid = 0; iss_unit = '0; iss_pc = '0;
        unit_done = '0; unit_r = '0; out_ready = 0;
    endtask

    task automatic issue(input int u, input logic [XLEN-1:0] pc);
        iss_valid = 1; iss_unit = UNIT_W'(u); iss_pc = pc;
        cycle();
        iss_valid = 0;
    endtask

    task automatic done1(input int u, input logic [XLEN-1:0] r);
        unit_done = '0;
        unit_done[u] = 1'b1;
        unit_r[u*XLEN +: XLEN] = r;
        cycle();
        unit_done = '0;
    endtask

    initial begin
        idle();
        rst = 1;
        m_err = 0;
        #12;
        compare_all();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Fill to DEPTH with the head blocked, then free one slot.
        for (int i = 0; i < 4; i++)
            issue(i, 32'h300 + 32'(4*i));
        check("full_ready", iss_ready, 0);
        check("full_stall", ex_stall, 1);
        check("full_count", count, 4);
        iss_valid = 1; iss_unit = 0; iss_pc = 32'h310;
        cycle();
        done1(0, 32'h99);
        iss_valid = 1; iss_unit = 0; iss_pc = 32'h310;
        out_ready = 1;
        cycle();
        check("pop_ready", iss_ready, 1);
        check("pop_count", count, 3);
        out_ready = 0;
        cycle();
        iss_valid = 0;
        check("wrap_count", count, 4);
        unit_done = 4'b1110;
        unit_r = {32'h33, 32'h22, 32'h11, 32'h0};
        cycle();
        done1(0, 32'h44);
        out_ready = 1;
        repeat (3) cycle();
        check("wrap_pc", out_pc, 32'h310);
        check("wrap_r", out_r, 32'h44);
        cycle();
        check("drain_count", count, 0);
        out_ready = 0;

        // Out-of-order completion, in-order retire.
        issue(0, 32'h200);
        issue(1, 32'h204);
        issue(2, 32'h208);
        done1(2, 32'hC);
        check("ooo_hold", out_valid, 0);
        done1(0, 32'hA);
        done1(1, 32'hB);
        cycle();
        check("hold_pc", out_pc, 32'h200);
        out_ready = 1;
        check("seq0_pc", out_pc, 32'h200);
        check("seq0_r", out_r, 32'hA);
        cycle();
        check("seq1_pc", out_pc, 32'h204);
        check("seq1_r", out_r, 32'hB);
        cycle();
        check("seq2_pc", out_pc, 32'h208);
        check("seq2_r", out_r, 32'hC);
        cycle();
        check("seq_empty", out_valid, 0);
        out_ready = 0;

        // Two pending entries on the same unit complete oldest first.
        issue(1, 32'h400);
        issue(1, 32'h404);
        done1(1, 32'h55);
        check("same_old_r", out_r, 32'h55);
        check("same_cnt", count, 2);
        done1(1, 32'h66);
        out_ready = 1;
        cycle();
        check("same_young_pc", out_pc, 32'h404);
        check("same_young_r", out_r, 32'h66);
        cycle();
        out_ready = 0;

        // Flush overrides a simultaneous issue, completion and pop.
        issue(0, 32'h500);
        issue(1, 32'h504);
        issue(2, 32'h508);
        flush = 1; iss_valid = 1; iss_unit = 3; iss_pc = 32'h50C;
        unit_done = 4'b0001; unit_r[31:0] = 32'h77; out_ready = 1;
        @(negedge clk);
        check("flush_ack", unit_ack, 0);
        @(posedge clk);
        #1;
        idle();
        mq.delete();
        check("flush_cnt", count, 0);
        check("flush_ov", out_valid, 0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            iss_valid = 1'($urandom);
            iss_unit  = UNIT_W'($urandom);
            iss_pc    = $urandom;
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            unit_done = '0;
            for (int k = 0; k < NU; k++) begin
                unit_r[k*XLEN +: XLEN] = $urandom;
                if (find_pending(k) >= 0 && $urandom_range(0, 2) != 0)
                    unit_done[k] = 1'b1;
            end
            cycle();
        end
        idle();
        flush = 1;
        cycle();
        flush = 0;

        // Done with an empty queue: no ack, sticky err; entry issued that cycle waits.
        iss_valid = 1; iss_unit = 3; iss_pc = 32'h600;
        unit_done = 4'b1000; unit_r[3*XLEN +: XLEN] = 32'hEE;
        @(negedge clk);
        check("orphan_ack", unit_ack[3], 0);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
        idle();
        check("orphan_err", err, 1);
        check("same_cycle_no_done", out_valid, 0);
        done1(3, 32'hEF);
        check("late_r", out_r, 32'hEF);
        out_ready = 1;
        repeat (3) cycle();
        check("err_sticky", err, 1);

        // Asynchronous reset in the middle of a burst.
        out_ready = 0;
        issue(0, 32'h700);
        issue(1, 32'h704);
        iss_valid = 1; iss_unit = 2; iss_pc = 32'h708;
        unit_done = 4'b0001;
        #2;
        rst = 1;
        mq.delete();
        m_err = 0;
        #1;
        compare_all();
        check("rst_ov", out_valid, 0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        issue(2, 32'h800);
        done1(2, 32'h81);
        out_ready = 1;
        check("post_rst_r", out_r, 32'h81);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_ex_retire.md
RISCV_EX_RETIRE -- requirements
Module: riscv_ex_retire

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter NUM_UNITS, default 4, number of execution-unit channels (2..8).
REQ-003 Parameter DEPTH, default 4, in-flight entries; power of 2, 2..16.
REQ-004 Derived constant UNIT_W = max(1, clog2(NUM_UNITS)); CNT_W = clog2(DEPTH)+1.
REQ-005 Ports (name direction width meaning); one clock, reset asynchronous active-high:
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous active-high reset
 flush  in  1  discard all in-flight entries
 iss_valid  in  1  instruction issued from ID
 iss_unit  in  UNIT_W  target unit index
 iss_pc  in  XLEN  instruction PC
 iss_ready  out  1  entry available
 unit_done  in  NUM_UNITS  per-unit result valid
 unit_r  in  NUM_UNITS*XLEN  per-unit result, unit k at bits [k*XLEN +: XLEN]
 unit_ack  out  NUM_UNITS  result accepted this cycle
 out_valid  out  1  head entry complete
 out_pc  out  XLEN  head PC
 out_r  out  XLEN  head result
 out_unit  out  UNIT_W  head unit index
 out_ready  in  1  MEM stage accepts
 ex_stall  out  1  equals !iss_ready
 count  out  CNT_W  occupied entries
 err  out  1  sticky: done from unit with no pending entry

Function
REQ-006 Circular queue of DEPTH entries {unit, pc, r, rdy}; write pointer, read pointer, count.
REQ-007 iss_ready SHALL be 1 iff count < DEPTH; no full-queue bypass even when a pop occurs same cycle.
REQ-008 Push on iss_valid & iss_ready: entry at write pointer gets unit=iss_unit, pc=iss_pc, rdy=0; pointer wraps DEPTH-1 -> 0.
REQ-009 iss_valid with iss_unit >= NUM_UNITS SHALL be pushed as normal and never complete (flush recovers).
REQ-010 Per cycle, for each unit k with unit_done[k]=1: oldest entry (from read pointer) with unit=k and rdy=0, present in queue before this edge, gets r=unit_r[k], rdy=1; unit_ack[k]=1 combinationally.
REQ-011 Entry pushed this cycle SHALL NOT be completed this cycle; minimum issue-to-out_valid latency 2 cycles.
REQ-012 Multiple units completing in one cycle SHALL all be accepted, each on its own entry.
REQ-013 unit_done[k] with no matching pending entry: unit_ack[k]=0, err set to 1 next edge.
REQ-014 out_valid = count!=0 & head.rdy; out_pc/out_r/out_unit driven from head entry; out_r=0 when count=0.
REQ-015 Pop on out_valid & out_ready; read pointer wraps; count = count + push - pop, simultaneous push/pop leaves count unchanged.
REQ-016 Completions strictly in issue order at output regardless of unit completion order.
REQ-017 flush SHALL clear pointers, count, all rdy bits next edge, override simultaneous push/done/pop, force unit_ack=0 that cycle; err unaffected.
REQ-018 Head entry with out_ready=0 SHALL hold out_* stable until popped or flushed.

Reset
REQ-019 On rst (asynchronous, active-high): pointers=0, count=0, all rdy=0, err=0; hence iss_ready=1, ex_stall=0, out_valid=0, out_r=0, unit_ack=0.
REQ-020 Reset mid-operation discards all entries; first cycle after release behaves as empty queue.
REQ-021 Entry pc/r/unit storage need no reset.

Structure
REQ-022 Entry struct typedef and UNIT_W/CNT_W helper functions SHALL reside in shared package riscv_ex_pkg.
REQ-023 One sub-module, riscv_ex_retire_match: per-unit oldest-pending-entry search (priority from read pointer), instantiated NUM_UNITS times.

Verification
REQ-024 Issue units 0,1,2 (PCs 0x200,0x204,0x208); done order 2,0,1 with r 0xC,0xA,0xB -> out sequence (0x200,0xA),(0x204,0xB),(0x208,0xC).
REQ-025 Issue 4 with DEPTH=4, out_ready=0 -> iss_ready=0, ex_stall=1, count=4; pop one -> iss_ready=1 next cycle, 5th issue lands in wrapped slot 0.
REQ-026 unit_done[3]=1 with queue empty -> unit_ack[3]=0, err=1 next cycle, stays 1 until rst.
REQ-027 Two pending unit-1 entries, done[1] once r=0x55 -> only older entry rdy; second done r=0x66 -> younger.
REQ-028 flush asserted with 3 entries, simultaneous issue and done[0] -> next cycle count=0, out_valid=0, unit_ack[0]=0 that cycle.
REQ-029 rst asserted asynchronously mid-burst -> all outputs at REQ-019 values before next clk edge.
